// File: rtl/i2c_regmap.sv
// Byte-wide register bank behind an I2C slave core: pointer protocol, auto-increment, host port.
// Optional macro I2C_REGMAP_RO_EN makes registers 0..RO_NUM-1 read-only from the I2C side.
module i2c_regmap #(
    parameter int unsigned REG_NUM = 16,
    parameter int unsigned PTR_W   = 4,
    parameter int unsigned RO_NUM  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             addr_hit,
    input  logic             addr_rw,
    input  logic             bus_start,
    input  logic             bus_stop,
    input  logic             tx_req,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic [PTR_W-1:0] ptr,
    output logic             wr_pulse
);

`ifdef I2C_REGMAP_RO_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        PTR,
        WDATA,
        RDATA
    } state_e;

    state_e           state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [7:0]       regs_q [REG_NUM];
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             wr_pulse_q;

    logic             bus_evt;
    logic             ro_hit;
    logic             wr_acc_d;
    logic             i2c_wr_d;
    logic             prefetch_d;

    // Stop/start outrank addr_hit, which outranks the byte-level strobes.
    always_comb begin
        bus_evt    = bus_stop || bus_start;
        ro_hit     = RO_EN && (32'(ptr_q) < RO_NUM);
        wr_acc_d   = !bus_evt && !addr_hit && rx_valid && (state_q == WDATA);
        i2c_wr_d   = wr_acc_d && !ro_hit;
        prefetch_d = !bus_evt && ((addr_hit && addr_rw) ||
                                  (!addr_hit && tx_req && (state_q == RDATA)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            wr_pulse_q <= 1'b0;
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            tx_valid_q <= prefetch_d;
            wr_pulse_q <= i2c_wr_d;

            if (bus_evt) begin
                state_q <= IDLE;
            end else if (addr_hit) begin
                state_q <= addr_rw ? RDATA : PTR;
            end else if (rx_valid && (state_q == PTR)) begin
                state_q <= WDATA;
            end

            if (!bus_evt && !addr_hit && rx_valid && (state_q == PTR)) begin
                ptr_q <= rx_data[PTR_W-1:0];
            end else if (wr_acc_d || prefetch_d) begin
                ptr_q <= ptr_q + 1'b1;
            end

            if (prefetch_d) begin
                tx_data_q <= regs_q[ptr_q];
            end

            // Host write to the same register takes precedence over the I2C write.
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                if (host_we && (host_addr == PTR_W'(i))) begin
                    regs_q[i] <= host_wdata;
                end else if (i2c_wr_d && (ptr_q == PTR_W'(i))) begin
                    regs_q[i] <= rx_data;
                end
            end
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign wr_pulse   = wr_pulse_q;
    assign ptr        = ptr_q;
    assign host_rdata = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_regmap.sv
// Directed bench for i2c_regmap with hand-computed expectations (REG_NUM=16, PTR_W=4, RO_NUM=2).
module tb_i2c_regmap;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_hit;
    logic       addr_rw;
    logic       bus_start;
    logic       bus_stop;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic [3:0] ptr;
    logic       wr_pulse;

    int unsigned checks = 0;
    int unsigned errors = 0;

    i2c_regmap #(
        .REG_NUM(16),
        .PTR_W  (4),
        .RO_NUM (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr_hit  (addr_hit),
        .addr_rw   (addr_rw),
        .bus_start (bus_start),
        .bus_stop  (bus_stop),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .ptr       (ptr),
        .wr_pulse  (wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rx_valid   = 1'b0;
        addr_hit   = 1'b0;
        addr_rw    = 1'b0;
        bus_start  = 1'b0;
        bus_stop   = 1'b0;
        tx_req     = 1'b0;
        host_we    = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic hit(input logic rw);
        addr_hit = 1'b1;
        addr_rw  = rw;
        tick();
        addr_hit = 1'b0;
        addr_rw  = 1'b0;
    endtask

    task automatic stop();
        bus_stop = 1'b1;
        tick();
        bus_stop = 1'b0;
    endtask

    task automatic start();
        bus_start = 1'b1;
        tick();
        bus_start = 1'b0;
    endtask

    task automatic txreq();
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        tick();
        host_we    = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        #1;
        check(tag, 32'(host_rdata), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rx_data    = '0;
        host_addr  = '0;
        host_wdata = '0;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_ptr", 32'(ptr), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_wr_pulse", 32'(wr_pulse), 32'h0);
        for (int i = 0; i < 16; i++) check_reg("rst_reg", 4'(i), 8'h00);

        // Write burst
        hit(1'b0);
        rx(8'h03);
        check("wb_ptr_set", 32'(ptr), 32'h3);
        check("wb_no_pulse_ptr", 32'(wr_pulse), 32'h0);
        rx(8'hAA);
        check("wb_pulse1", 32'(wr_pulse), 32'h1);
        check("wb_ptr4", 32'(ptr), 32'h4);
        rx(8'hBB);
        check("wb_pulse2", 32'(wr_pulse), 32'h1);
        stop();
        check("wb_pulse_end", 32'(wr_pulse), 32'h0);
        check("wb_ptr5", 32'(ptr), 32'h5);
        check_reg("wb_reg3", 4'd3, 8'hAA);
        check_reg("wb_reg4", 4'd4, 8'hBB);
        check_reg("wb_reg5", 4'd5, 8'h00);

        // Combined read with wrap
        host_wr(4'd14, 8'hE1);
        host_wr(4'd15, 8'hF2);
        host_wr(4'd0, 8'h10);
        host_wr(4'd1, 8'h21);
        hit(1'b0);
        rx(8'h0E);
        start();
        check("cr_ptr14", 32'(ptr), 32'hE);
        hit(1'b1);
        check("cr_tv0", 32'(tx_valid), 32'h1);
        check("cr_td0", 32'(tx_data), 32'hE1);
        tick();
        check("cr_tv_drop", 32'(tx_valid), 32'h0);
        check("cr_td_hold", 32'(tx_data), 32'hE1);
        txreq();
        check("cr_td1", 32'(tx_data), 32'hF2);
        check("cr_tv1", 32'(tx_valid), 32'h1);
        txreq();
        check("cr_td2_wrap", 32'(tx_data), 32'h10);
        txreq();
        check("cr_td3", 32'(tx_data), 32'h21);
        check("cr_ptr2", 32'(ptr), 32'h2);
        rx(8'h77);
        check("cr_rx_ignored_pulse", 32'(wr_pulse), 32'h0);
        check("cr_rx_ignored_ptr", 32'(ptr), 32'h2);
        check_reg("cr_reg2", 4'd2, 8'h00);
        stop();

        // Host/I2C collision on the same and on different registers
        hit(1'b0);
        rx(8'h05);
        host_we    = 1'b1;
        host_addr  = 4'd5;
        host_wdata = 8'h11;
        rx_data    = 8'h22;
        rx_valid   = 1'b1;
        tick();
        clear_inputs();
        check("col_pulse", 32'(wr_pulse), 32'h1);
        check("col_ptr", 32'(ptr), 32'h6);
        check_reg("col_reg5", 4'd5, 8'h11);
        host_we    = 1'b1;
        host_addr  = 4'd9;
        host_wdata = 8'h99;
        rx_data    = 8'h66;
        rx_valid   = 1'b1;
        tick();
        clear_inputs();
        check_reg("col_reg6", 4'd6, 8'h66);
        check_reg("col_reg9", 4'd9, 8'h99);
        stop();

        // Pointer byte upper bits ignored
        hit(1'b0);
        rx(8'h93);
        check("ptr_mask", 32'(ptr), 32'h3);
        stop();

        // Writes to the low registers (read-only when the macro is defined)
        hit(1'b0);
        rx(8'h00);
        rx(8'h55);
`ifdef I2C_REGMAP_RO_EN
        check("ro_pulse0", 32'(wr_pulse), 32'h0);
`else
        check("ro_pulse0", 32'(wr_pulse), 32'h1);
`endif
        rx(8'h66);
`ifdef I2C_REGMAP_RO_EN
        check("ro_pulse1", 32'(wr_pulse), 32'h0);
`else
        check("ro_pulse1", 32'(wr_pulse), 32'h1);
`endif
        check("ro_ptr", 32'(ptr), 32'h2);
        stop();
`ifdef I2C_REGMAP_RO_EN
        check_reg("ro_reg0", 4'd0, 8'h10);
        check_reg("ro_reg1", 4'd1, 8'h21);
`else
        check_reg("ro_reg0", 4'd0, 8'h55);
        check_reg("ro_reg1", 4'd1, 8'h66);
`endif

        // Stop outranks addr_hit; idle ignores rx and tx_req
        bus_stop = 1'b1;
        addr_hit = 1'b1;
        tick();
        clear_inputs();
        rx(8'h0A);
        check("prio_ptr", 32'(ptr), 32'h2);
        check("prio_pulse", 32'(wr_pulse), 32'h0);
        txreq();
        check("idle_txreq_tv", 32'(tx_valid), 32'h0);
        check("idle_txreq_ptr", 32'(ptr), 32'h2);

        // Reset mid-burst
        hit(1'b0);
        rx(8'h07);
        check("mr_ptr7", 32'(ptr), 32'h7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_ptr0", 32'(ptr), 32'h0);
        check("mr_tx_data", 32'(tx_data), 32'h00);
        check_reg("mr_reg3", 4'd3, 8'h00);
        check_reg("mr_reg9", 4'd9, 8'h00);
        rx(8'h44);
        check("mr_rx_ignored_ptr", 32'(ptr), 32'h0);
        check("mr_rx_ignored_pulse", 32'(wr_pulse), 32'h0);
        check_reg("mr_reg0", 4'd0, 8'h00);
        hit(1'b0);
        rx(8'h02);
        check("mr_rehit_ptr", 32'(ptr), 32'h2);
        stop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
